// File: rtl/evr_trigger_pkg.sv
// Shared constants for the EVR hardware trigger outputs: CSR field selects,
// the idle event code and the per-channel state encoding.
package evr_trigger_pkg;

  localparam logic [2:0] FIELD_CODE     = 3'd0;
  localparam logic [2:0] FIELD_DELAY    = 3'd1;
  localparam logic [2:0] FIELD_WIDTH    = 3'd2;
  localparam logic [2:0] FIELD_POLARITY = 3'd3;

  // Code 0 is "no event": it is never matched and disables a channel.
  localparam int unsigned EVCODE_IDLE = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    PULSE = 2'd2
  } chState_t;

endpackage

// File: rtl/evr_trigger_channel.sv
// One hardware trigger channel: event-code match, delay down-counter, then a
// pulse whose length is set by the width down-counter.
//
// state | meaning
// IDLE  | waiting for a match on the programmed code
// DELAY | counting down the programmed delay; a new match restarts it
// PULSE | output active while the width counter runs down; matches ignored
module evr_trigger_channel
  import evr_trigger_pkg::*;
#(
  parameter int EVENTCODE_WIDTH = 8,
  parameter int COUNTER_WIDTH   = 16
) (
  input  logic                       evrRxClk,
  input  logic                       evrRxReset_n,
  input  logic [EVENTCODE_WIDTH-1:0] rxCode,
  input  logic [EVENTCODE_WIDTH-1:0] chCode,
  input  logic [COUNTER_WIDTH-1:0]   delay,
  input  logic [COUNTER_WIDTH-1:0]   width,
  output logic                       active
);

  localparam logic [COUNTER_WIDTH-1:0] CNT_ONE = COUNTER_WIDTH'(1);

  chState_t                 state, stateNext;
  logic [COUNTER_WIDTH-1:0] cnt, cntNext, widthLoad;
  logic                     codeEnabled, match;

  assign codeEnabled = (chCode != EVENTCODE_WIDTH'(EVCODE_IDLE));
  assign match       = codeEnabled && (rxCode == chCode);
  // Counters terminate at 0, so load N-1 to get N cycles; width 0 acts as 1.
  assign widthLoad   = (width == '0) ? '0 : width - CNT_ONE;

  always_ff @(posedge evrRxClk or negedge evrRxReset_n) begin
    if (!evrRxReset_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
    end
  end

  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    case (state)
      IDLE, DELAY: begin
        if (match) begin
          if (delay == '0) begin
            stateNext = PULSE;
            cntNext   = widthLoad;
          end else begin
            stateNext = DELAY;
            cntNext   = delay - CNT_ONE;
          end
        end else if (state == DELAY) begin
          if (cnt == '0) begin
            stateNext = PULSE;
            cntNext   = widthLoad;
          end else begin
            cntNext = cnt - CNT_ONE;
          end
        end
      end
      PULSE: begin
        if (cnt == '0) stateNext = IDLE;
        else           cntNext   = cnt - CNT_ONE;
      end
      default: begin
        stateNext = IDLE;
        cntNext   = '0;
      end
    endcase
    if (!codeEnabled) begin
      stateNext = IDLE;
      cntNext   = '0;
    end
  end

  // Gating with codeEnabled drops the output the cycle after code 0 is written.
  assign active = (state == PULSE) && codeEnabled;

endmodule

// File: rtl/evr_hardware_trigger_outputs.sv
// EVR hardware trigger outputs: CSR decode/config, event input register,
// readback mux and one trigger channel per output. EVR_TRIGGER_POLARITY_EN adds per-channel invert.
module evr_hardware_trigger_outputs
  import evr_trigger_pkg::*;
#(
  parameter int OUTPUT_COUNT    = 6,
  parameter int EVENTCODE_WIDTH = 8,
  parameter int COUNTER_WIDTH   = 16
) (
  input  logic                       evrRxClk,
  input  logic                       evrRxReset_n,
  input  logic                       csrStrobe,
  input  logic [31:0]                csrGPIO_OUT,
  output logic [31:0]                status,
  input  logic [EVENTCODE_WIDTH-1:0] eventTDATA,
  input  logic                       eventTVALID,
  output logic                       eventTREADY,
  output logic [OUTPUT_COUNT-1:0]    triggers
);

  logic                       csrWrite;
  logic [2:0]                 csrField, rdField;
  logic [3:0]                 csrChan, rdChan;
  logic [EVENTCODE_WIDTH-1:0] codeCfg  [OUTPUT_COUNT];
  logic [COUNTER_WIDTH-1:0]   delayCfg [OUTPUT_COUNT];
  logic [COUNTER_WIDTH-1:0]   widthCfg [OUTPUT_COUNT];
  logic [EVENTCODE_WIDTH-1:0] rxCode;
  logic                       readyReg;
  logic [OUTPUT_COUNT-1:0]    active;
  logic [15:0]                rdData;
  logic                       unusedCsrBits;

  assign csrWrite      = csrStrobe && csrGPIO_OUT[31];
  assign csrField      = csrGPIO_OUT[30:28];
  assign csrChan       = csrGPIO_OUT[27:24];
  assign unusedCsrBits = ^csrGPIO_OUT;

  always_ff @(posedge evrRxClk or negedge evrRxReset_n) begin
    if (!evrRxReset_n) begin
      for (int i = 0; i < OUTPUT_COUNT; i++) begin
        codeCfg[i]  <= '0;
        delayCfg[i] <= '0;
        widthCfg[i] <= '0;
      end
    end else begin
      for (int i = 0; i < OUTPUT_COUNT; i++) begin
        if (csrWrite && (csrChan == 4'(i))) begin
          case (csrField)
            FIELD_CODE:  codeCfg[i]  <= csrGPIO_OUT[EVENTCODE_WIDTH-1:0];
            FIELD_DELAY: delayCfg[i] <= csrGPIO_OUT[COUNTER_WIDTH-1:0];
            FIELD_WIDTH: widthCfg[i] <= csrGPIO_OUT[COUNTER_WIDTH-1:0];
            default: ;
          endcase
        end
      end
    end
  end

  // Ready drops for the cycle after a write so config never changes under a compare.
  always_ff @(posedge evrRxClk or negedge evrRxReset_n) begin
    if (!evrRxReset_n) begin
      rdChan   <= '0;
      rdField  <= '0;
      rxCode   <= EVENTCODE_WIDTH'(EVCODE_IDLE);
      readyReg <= 1'b0;
    end else begin
      if (csrStrobe) begin
        rdChan  <= csrChan;
        rdField <= csrField;
      end
      rxCode   <= (eventTVALID && readyReg) ? eventTDATA : EVENTCODE_WIDTH'(EVCODE_IDLE);
      readyReg <= !csrWrite;
    end
  end

  assign eventTREADY = readyReg;

  for (genvar g = 0; g < OUTPUT_COUNT; g++) begin : gCh
    evr_trigger_channel #(
      .EVENTCODE_WIDTH(EVENTCODE_WIDTH),
      .COUNTER_WIDTH  (COUNTER_WIDTH)
    ) uCh (
      .evrRxClk    (evrRxClk),
      .evrRxReset_n(evrRxReset_n),
      .rxCode      (rxCode),
      .chCode      (codeCfg[g]),
      .delay       (delayCfg[g]),
      .width       (widthCfg[g]),
      .active      (active[g])
    );
  end

`ifdef EVR_TRIGGER_POLARITY_EN
  logic [OUTPUT_COUNT-1:0] invertCfg;

  always_ff @(posedge evrRxClk or negedge evrRxReset_n) begin
    if (!evrRxReset_n) begin
      invertCfg <= '0;
    end else begin
      for (int i = 0; i < OUTPUT_COUNT; i++) begin
        if (csrWrite && (csrChan == 4'(i)) && (csrField == FIELD_POLARITY))
          invertCfg[i] <= csrGPIO_OUT[0];
      end
    end
  end

  assign triggers = active ^ invertCfg;
`else
  assign triggers = active;
`endif

  always_comb begin
    rdData = '0;
    for (int i = 0; i < OUTPUT_COUNT; i++) begin
      if (rdChan == 4'(i)) begin
        case (rdField)
          FIELD_CODE:     rdData = 16'(codeCfg[i]);
          FIELD_DELAY:    rdData = 16'(delayCfg[i]);
          FIELD_WIDTH:    rdData = 16'(widthCfg[i]);
`ifdef EVR_TRIGGER_POLARITY_EN
          FIELD_POLARITY: rdData = 16'(invertCfg[i]);
`endif
          default: ;
        endcase
      end
    end
  end

  assign status = {16'(triggers), rdData};

endmodule
